// File: rtl/tt_ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: enables the oscillator, waits a settling time,
// then counts synchronized rising edges of osc_in over a gate window and publishes the result.
module tt_ringosc_meas_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic [SetW-1:0]     settle_q;
  logic [GATE_W-1:0]   gate_q;
  logic [CNT_W-1:0]    acc_q;
  logic                sat_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;

  logic                osc_meta_q;
  logic                osc_sync_q;
  logic                osc_hist_q;
  logic                osc_rise;
  logic [CNT_W-1:0]    acc_inc;
  logic                sat_inc;

  // Synchronizer and history run in every state so the edge detector is primed on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_meta_q <= 1'b0;
      osc_sync_q <= 1'b0;
      osc_hist_q <= 1'b0;
    end else begin
      osc_meta_q <= osc_in;
      osc_sync_q <= osc_meta_q;
      osc_hist_q <= osc_sync_q;
    end
  end

  assign osc_rise = osc_sync_q & ~osc_hist_q;

  // Saturating accumulate; an edge seen while pinned at max marks the result as overflowed.
  always_comb begin
    acc_inc = acc_q;
    sat_inc = sat_q;
    if (osc_rise) begin
      if (acc_q == CntMax) begin
        sat_inc = 1'b1;
      end else begin
        acc_inc = acc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= '0;
      gate_q   <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSettle;
            busy_q   <= 1'b1;
            gate_q   <= gate_len;
            settle_q <= SettleLoad;
            acc_q    <= '0;
            sat_q    <= 1'b0;
          end
        end
        StSettle: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (settle_q == '0) begin
            if (gate_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= '0;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= StMeasure;
            end
          end else begin
            settle_q <= settle_q - SetW'(1);
          end
        end
        StMeasure: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_inc;
            sat_q <= sat_inc;
            // The last window cycle's edge is folded straight into the published value.
            if (gate_q == GATE_W'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= acc_inc;
              ovf_q   <= sat_inc;
            end else begin
              gate_q <= gate_q - GATE_W'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign osc_en = busy_q;
  assign done   = done_q;
  assign count  = count_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_tt_ringosc_meas_ctrl.sv
// Randomized and directed bench for tt_ringosc_meas_ctrl; two instances (16-bit and 8-bit
// counters) share stimulus and are checked every cycle against an edge-indexed window model.
module tb_tt_ringosc_meas_ctrl;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gate_len = '0;
  logic        osc_in = 1'b0;

  logic        osc_en16, busy16, done16, ovf16;
  logic [15:0] count16;
  logic        osc_en8, busy8, done8, ovf8;
  logic [7:0]  count8;

  int checks = 0;
  int errors = 0;
  int osc_half = 4;   // 0 selects random osc_in
  int osc_ph = 0;

  tt_ringosc_meas_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYC(S)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en16), .busy(busy16), .done(done16), .count(count16),
    .ovf(ovf16)
  );

  tt_ringosc_meas_ctrl #(.CNT_W(8), .GATE_W(16), .SETTLE_CYC(S)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en8), .busy(busy8), .done(done8), .count(count8),
    .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act, input int lo,
                             input int hi);
    checks++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Oscillator source, changes only on falling clk edges.
  initial begin
    forever begin
      @(negedge clk);
      if (osc_half == 0) begin
        osc_in = 1'($urandom_range(0, 1));
      end else begin
        osc_ph++;
        if (osc_ph >= osc_half) begin
          osc_ph = 0;
          osc_in = ~osc_in;
        end
      end
    end
  end

  // Model: edge n samples osc(n); a measurement accepted at edge T counts edges
  // T+S+1..T+S+G, where edge n sees a rise iff osc(n-2)=1 and osc(n-3)=0.
  bit          s_hist [0:131071];
  int          n, m_t, m_g, raw;
  bit          m_busy, m_done, m_o16, m_o8;
  logic [15:0] m_c16;
  logic [7:0]  m_c8;

  function automatic bit samp(input int k);
    return (k < 0) ? 1'b0 : s_hist[k];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; m_busy = 0; m_done = 0; raw = 0;
        m_c16 = '0; m_o16 = 0; m_c8 = '0; m_o8 = 0;
      end else begin
        s_hist[n] = osc_in;
        m_done = 0;
        if (m_busy) begin
          if (abort) begin
            m_busy = 0;
          end else begin
            if (n > m_t + S && n <= m_t + S + m_g && samp(n - 2) && !samp(n - 3)) raw++;
            if (n == m_t + S + m_g) begin
              m_busy = 0;
              m_done = 1;
              m_o16 = raw > 65535;
              m_c16 = m_o16 ? 16'hffff : 16'(raw);
              m_o8  = raw > 255;
              m_c8  = m_o8 ? 8'hff : 8'(raw);
            end
          end
        end else if (start) begin
          m_busy = 1; m_t = n; m_g = int'(gate_len); raw = 0;
        end
        n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cycle16", {osc_en16, busy16, done16, ovf16, count16},
              {m_busy, m_busy, m_done, m_o16, m_c16});
        check("cycle8", {osc_en8, busy8, done8, ovf8, count8},
              {m_busy, m_busy, m_done, m_o8, m_c8});
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start_pulse(input int g);
    @(negedge clk);
    gate_len = 16'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first falling edge after acceptance (lat=1); lat=-1 on timeout.
  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc = 0;
    while (!done16) begin
      if (busy16) bc++;
      @(negedge clk);
      lat++;
      if (lat > 5000) begin
        lat = -1;
        return;
      end
    end
  endtask

  int lat, bc, nd, dl;

  initial begin
    cyc(3);
    check("reset outputs16", {osc_en16, busy16, done16, ovf16, count16}, 32'h0);
    check("reset outputs8", {osc_en8, busy8, done8, ovf8, count8}, 32'h0);
    #2 rst_n = 1'b1;
    cyc(4);

    // Nominal: period 8, 800-cycle gate.
    osc_half = 4;
    start_pulse(800);
    wait_done(lat, bc);
    check("nominal latency", lat, 817);
    check("nominal busy cycles", bc, 816);
    check_range("nominal count", count16, 99, 101);
    check("nominal ovf", ovf16, 0);

    // Saturation on the 8-bit instance.
    osc_half = 2;
    start_pulse(2000);
    wait_done(lat, bc);
    check("sat count8", count8, 255);
    check("sat ovf8", ovf8, 1);
    check_range("sat count16", count16, 499, 501);
    check("sat ovf16", ovf16, 0);
    osc_half = 8;
    start_pulse(160);
    wait_done(lat, bc);
    check_range("period16 count8", count8, 9, 11);
    check("period16 ovf8", ovf8, 0);

    // Abort 5 cycles into MEASURE.
    osc_half = 3;
    start_pulse(100);
    cyc(S + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy16, 0);
    check("abort osc_en", osc_en16, 0);
    check_range("abort count kept", count16, 9, 11);
    nd = 0;
    for (int k = 0; k < 150; k++) begin
      if (done16) nd++;
      @(negedge clk);
    end
    check("abort no done", nd, 0);
    start_pulse(50);
    wait_done(lat, bc);
    check("after abort latency", lat, S + 50 + 1);

    // Start while busy is ignored.
    start_pulse(40);
    nd = 0;
    dl = 0;
    for (int k = 1; k <= 100; k++) begin
      start = (k == 5 || k == 25);
      if (done16) begin
        nd++;
        dl = k;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy start done count", nd, 1);
    check("busy start done cycle", dl, S + 40 + 1);

    // Zero gate.
    start_pulse(0);
    wait_done(lat, bc);
    check("zero gate latency", lat, S + 1);
    check("zero gate count", count16, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    gate_len = 16'd4;
    start = 1'b1;
    nd = 0;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      if (done16) nd++;
    end
    start = 1'b0;
    check("back-to-back dones", nd, 5);
    cyc(30);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k % 500 == 0) osc_half = $urandom_range(0, 5);
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 149) == 0);
      gate_len = 16'($urandom_range(0, 60));
    end
    start = 1'b0;
    abort = 1'b0;
    cyc(120);

    // Asynchronous reset mid-MEASURE.
    osc_half = 2;
    start_pulse(500);
    cyc(S + 20);
    #3 rst_n = 1'b0;
    #1;
    check("async rst outputs16", {osc_en16, busy16, done16, ovf16, count16}, 32'h0);
    check("async rst outputs8", {osc_en8, busy8, done8, ovf8, count8}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(20);
    check("post reset idle", busy16, 0);
    start_pulse(10);
    wait_done(lat, bc);
    check("post reset latency", lat, S + 10 + 1);
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
